csr_file_m: RTL and testbench

Parametrised machine-mode CSR file. It replaces the fixed four-register CSR bank with address-decoded CSR access supporting the RW, RS and RC operations. It adds trap entry and mret sequencing with mstatus MIE/MPIE stacking, vectored mtvec, and free-running 64-bit mcycle and minstret counters. It sits beside the commit stage, and CSR instructions and traps are presented in commit order.

---
 rtl/csr_file_m_if.sv | 40 ++++
 rtl/csr_file_m.sv | 175 +++++++++++++++++
 tb/tb_csr_file_m.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_m_if.sv
// CSR file bus bundle: CSR access, trap/mret requests, retire count and
// the architectural register views exported by the CSR file.
interface csr_file_m_if #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 2
);
  logic [11:0]         csr_addr;
  logic [1:0]          csr_op;
  logic [XLEN-1:0]     csr_wdata;
  logic [XLEN-1:0]     csr_rdata;
  logic                csr_illegal;
  logic                trap_valid;
  logic [XLEN-1:0]     trap_cause;
  logic [XLEN-1:0]     trap_pc;
  logic [XLEN-1:0]     trap_target;
  logic                mret_valid;
  logic [XLEN-1:0]     mret_target;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [XLEN-1:0]     mstatus_out;
  logic [XLEN-1:0]     mtvec_out;
  logic [XLEN-1:0]     mepc_out;
  logic [XLEN-1:0]     mcause_out;
  logic                mie_out;

  // Commit stage side: issues accesses and requests, observes results
  modport master (
    output csr_addr, csr_op, csr_wdata, trap_valid, trap_cause, trap_pc,
           mret_valid, retire_cnt,
    input  csr_rdata, csr_illegal, trap_target, mret_target,
           mstatus_out, mtvec_out, mepc_out, mcause_out, mie_out
  );

  // CSR file side
  modport slave (
    input  csr_addr, csr_op, csr_wdata, trap_valid, trap_cause, trap_pc,
           mret_valid, retire_cnt,
    output csr_rdata, csr_illegal, trap_target, mret_target,
           mstatus_out, mtvec_out, mepc_out, mcause_out, mie_out
  );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: decoded RW/RS/RC access, trap entry and mret with
// MIE/MPIE stacking, direct/vectored mtvec, 64-bit mcycle and minstret.
module csr_file_m #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET   = '0,
  parameter logic [31:0]     MSTATUS_RESET = 32'h1800,
  parameter logic [31:0]     MVENDORID     = 32'h79737978,
  parameter logic [31:0]     MARCHID       = 32'h016FBCBD,
  parameter int              RETIRE_W      = 2
) (
  input  logic         clock,
  input  logic         reset,
  csr_file_m_if.slave  bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  // Only MIE (bit 3) and MPIE (bit 7) are writable; MPP (12:11) is fixed at 11
  localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(32'h0000_0088);
  localparam logic [XLEN-1:0] MPP_BITS      = XLEN'(32'h0000_1800);
  localparam logic [XLEN-1:0] MSTATUS_INIT  = XLEN'(MSTATUS_RESET) | MPP_BITS;

  // Modes 2 and 3 are reserved, so they collapse to direct mode
  function automatic logic [XLEN-1:0] legalTvec(input logic [XLEN-1:0] v);
    return v[1] ? {v[XLEN-1:2], 2'b00} : v;
  endfunction

  localparam logic [XLEN-1:0] MTVEC_INIT = legalTvec(MTVEC_RESET);

  logic [XLEN-1:0]     r_mstatus;
  logic [XLEN-1:0]     r_mtvec;
  logic [XLEN-1:0]     r_mscratch;
  logic [XLEN-1:0]     r_mepc;
  logic [XLEN-1:0]     r_mcause;
  logic [63:0]         r_mcycle;
  logic [63:0]         r_minstret;

  logic                w_mapped;
  logic [XLEN-1:0]     w_rvalue;
  logic                w_illegal;
  logic [XLEN-1:0]     w_newval;
  logic [63:0]         w_newWide;
  logic                w_we;
  logic [RETIRE_W-1:0] w_retire;
  logic [XLEN-1:0]     w_tvecBase;

  assign w_retire  = bus.retire_cnt;
  assign w_newWide = 64'(w_newval);

  // Address decode and read mux; unmapped addresses read as zero
  always_comb begin
    w_mapped = 1'b1;
    w_rvalue = '0;
    case (bus.csr_addr)
      A_MSTATUS:   w_rvalue = r_mstatus;
      A_MTVEC:     w_rvalue = r_mtvec;
      A_MSCRATCH:  w_rvalue = r_mscratch;
      A_MEPC:      w_rvalue = r_mepc;
      A_MCAUSE:    w_rvalue = r_mcause;
      A_MCYCLE:    w_rvalue = XLEN'(r_mcycle);
      A_MINSTRET:  w_rvalue = XLEN'(r_minstret);
      A_MCYCLEH: begin
        if (XLEN == 32) w_rvalue = XLEN'(r_mcycle[63:32]);
        else            w_mapped = 1'b0;
      end
      A_MINSTRETH: begin
        if (XLEN == 32) w_rvalue = XLEN'(r_minstret[63:32]);
        else            w_mapped = 1'b0;
      end
      A_MVENDORID: w_rvalue = XLEN'(MVENDORID);
      A_MARCHID:   w_rvalue = XLEN'(MARCHID);
      default:     w_mapped = 1'b0;
    endcase
  end

  assign w_illegal = (bus.csr_op != 2'b00) &&
                     (!w_mapped || (bus.csr_addr[11:10] == 2'b11));

  // Write value from the access operation applied to the pre-write contents
  always_comb begin
    w_newval = w_rvalue;
    case (bus.csr_op)
      2'b01:   w_newval = bus.csr_wdata;
      2'b10:   w_newval = w_rvalue | bus.csr_wdata;
      2'b11:   w_newval = w_rvalue & ~bus.csr_wdata;
      default: w_newval = w_rvalue;
    endcase
  end

  // A trap or mret in the same cycle swallows the CSR write
  assign w_we = (bus.csr_op != 2'b00) && !w_illegal &&
                !bus.trap_valid && !bus.mret_valid;

  // Status, vector, scratch, epc and cause: trap beats mret beats CSR write
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mstatus  <= MSTATUS_INIT;
      r_mtvec    <= MTVEC_INIT;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (bus.trap_valid) begin
      r_mepc       <= {bus.trap_pc[XLEN-1:2], 2'b00};
      r_mcause     <= bus.trap_cause;
      r_mstatus[7] <= r_mstatus[3];
      r_mstatus[3] <= 1'b0;
    end else if (bus.mret_valid) begin
      r_mstatus[3] <= r_mstatus[7];
      r_mstatus[7] <= 1'b1;
    end else if (w_we) begin
      case (bus.csr_addr)
        A_MSTATUS:  r_mstatus  <= (w_newval & MSTATUS_WMASK) | MPP_BITS;
        A_MTVEC:    r_mtvec    <= legalTvec(w_newval);
        A_MSCRATCH: r_mscratch <= w_newval;
        A_MEPC:     r_mepc     <= {w_newval[XLEN-1:2], 2'b00};
        A_MCAUSE:   r_mcause   <= w_newval;
        default:    ;
      endcase
    end
  end

  // mcycle: a write to either half replaces it and skips this cycle's count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcycle <= '0;
    end else if (w_we && bus.csr_addr == A_MCYCLE) begin
      if (XLEN == 32) r_mcycle[31:0] <= w_newval[31:0];
      else            r_mcycle       <= w_newWide;
    end else if (w_we && bus.csr_addr == A_MCYCLEH) begin
      r_mcycle[63:32] <= w_newval[31:0];
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  // minstret: same write rules as mcycle, counting retired instructions
  always_ff @(posedge clock) begin
    if (reset) begin
      r_minstret <= '0;
    end else if (w_we && bus.csr_addr == A_MINSTRET) begin
      if (XLEN == 32) r_minstret[31:0] <= w_newval[31:0];
      else            r_minstret       <= w_newWide;
    end else if (w_we && bus.csr_addr == A_MINSTRETH) begin
      r_minstret[63:32] <= w_newval[31:0];
    end else begin
      r_minstret <= r_minstret + 64'(w_retire);
    end
  end

  assign w_tvecBase = {r_mtvec[XLEN-1:2], 2'b00};

  // Vectored mode offsets interrupts by 4*cause; the shift drops the interrupt flag
  assign bus.trap_target = (r_mtvec[1:0] == 2'b01 && bus.trap_cause[XLEN-1]) ?
                           w_tvecBase + (bus.trap_cause << 2) : w_tvecBase;

  assign bus.csr_rdata   = w_illegal ? '0 : w_rvalue;
  assign bus.csr_illegal = w_illegal;
  assign bus.mret_target = r_mepc;
  assign bus.mstatus_out = r_mstatus;
  assign bus.mtvec_out   = r_mtvec;
  assign bus.mepc_out    = r_mepc;
  assign bus.mcause_out  = r_mcause;
  assign bus.mie_out     = r_mstatus[3];

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: directed steps followed by random
// traffic, compared against an architectural model of the CSR state.
module tb_csr_file_m;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  csr_file_m_if #(.XLEN(32), .RETIRE_W(2)) bus ();

  csr_file_m #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int compareCount = 0;
  int failCount    = 0;

  // Architectural model state
  bit        mMie, mMpie;
  bit [31:0] mMtvec, mMepc, mMcause, mMscratch;
  bit [63:0] mMcycle, mMinstret;

  function automatic bit [31:0] modelMstatus();
    return 32'h1800 | (32'(mMie) << 3) | (32'(mMpie) << 7);
  endfunction

  function automatic void modelRead(input bit [11:0] a, output bit mapped,
                                    output bit [31:0] v);
    mapped = 1'b1;
    v = 32'h0;
    case (a)
      12'h300: v = modelMstatus();
      12'h305: v = mMtvec;
      12'h340: v = mMscratch;
      12'h341: v = mMepc;
      12'h342: v = mMcause;
      12'hB00: v = mMcycle[31:0];
      12'hB80: v = mMcycle[63:32];
      12'hB02: v = mMinstret[31:0];
      12'hB82: v = mMinstret[63:32];
      12'hF11: v = 32'h79737978;
      12'hF12: v = 32'h016FBCBD;
      default: mapped = 1'b0;
    endcase
  endfunction

  function automatic bit modelIllegal(input bit [11:0] a, input bit [1:0] op);
    bit mapped;
    bit [31:0] v;
    modelRead(a, mapped, v);
    return (op != 2'b00) && (!mapped || a[11:10] == 2'b11);
  endfunction

  function automatic bit [31:0] modelTrapTarget(input bit [31:0] cause);
    bit [31:0] base;
    base = mMtvec & ~32'h3;
    if (mMtvec[1:0] == 2'b01 && cause[31])
      return base + 32'd4 * (cause & 32'h7FFF_FFFF);
    return base;
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic modelStep();
    bit [63:0] nextCycle, nextInstret;
    bit [31:0] oldV, newV;
    bit        mapped, tmp;
    if (reset) begin
      mMie = 1'b0; mMpie = 1'b0;
      mMtvec = 32'h0; mMepc = 32'h0; mMcause = 32'h0; mMscratch = 32'h0;
      mMcycle = 64'h0; mMinstret = 64'h0;
      return;
    end
    nextCycle   = mMcycle + 64'd1;
    nextInstret = mMinstret + 64'(bus.retire_cnt);
    if (bus.trap_valid) begin
      mMepc   = bus.trap_pc & ~32'h3;
      mMcause = bus.trap_cause;
      mMpie   = mMie;
      mMie    = 1'b0;
    end else if (bus.mret_valid) begin
      tmp   = mMpie;
      mMpie = 1'b1;
      mMie  = tmp;
    end else if (bus.csr_op != 2'b00 && !modelIllegal(bus.csr_addr, bus.csr_op)) begin
      modelRead(bus.csr_addr, mapped, oldV);
      case (bus.csr_op)
        2'b01:   newV = bus.csr_wdata;
        2'b10:   newV = oldV | bus.csr_wdata;
        default: newV = oldV & ~bus.csr_wdata;
      endcase
      case (bus.csr_addr)
        12'h300: begin mMie = newV[3]; mMpie = newV[7]; end
        12'h305: mMtvec = (newV[1:0] >= 2'd2) ? (newV & ~32'h3) : newV;
        12'h340: mMscratch = newV;
        12'h341: mMepc = newV & ~32'h3;
        12'h342: mMcause = newV;
        12'hB00: nextCycle = {mMcycle[63:32], newV};
        12'hB80: nextCycle = {newV, mMcycle[31:0]};
        12'hB02: nextInstret = {mMinstret[63:32], newV};
        12'hB82: nextInstret = {newV, mMinstret[31:0]};
        default: ;
      endcase
    end
    mMcycle   = nextCycle;
    mMinstret = nextInstret;
  endtask

  // Present one cycle of inputs and let combinational outputs settle
  task automatic applyStimulus(input bit [11:0] addr, input bit [1:0] op,
                               input bit [31:0] wdata, input bit trap,
                               input bit [31:0] cause, input bit [31:0] pc,
                               input bit mret, input bit [1:0] retire);
    bus.csr_addr   = addr;
    bus.csr_op     = op;
    bus.csr_wdata  = wdata;
    bus.trap_valid = trap;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.mret_valid = mret;
    bus.retire_cnt = retire;
    #1;
  endtask

  task automatic clockStep();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compareCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model for the current inputs
  task automatic checkAll(input string tag);
    bit        mapped, ill;
    bit [31:0] v;
    modelRead(bus.csr_addr, mapped, v);
    ill = modelIllegal(bus.csr_addr, bus.csr_op);
    checkOutput({tag, ".rdata"},   bus.csr_rdata,   ill ? 32'h0 : v);
    checkOutput({tag, ".illegal"}, bus.csr_illegal, ill);
    checkOutput({tag, ".ttarget"}, bus.trap_target, modelTrapTarget(bus.trap_cause));
    checkOutput({tag, ".mret"},    bus.mret_target, mMepc);
    checkOutput({tag, ".mstatus"}, bus.mstatus_out, modelMstatus());
    checkOutput({tag, ".mtvec"},   bus.mtvec_out,   mMtvec);
    checkOutput({tag, ".mepc"},    bus.mepc_out,    mMepc);
    checkOutput({tag, ".mcause"},  bus.mcause_out,  mMcause);
    checkOutput({tag, ".mie"},     bus.mie_out,     mMie);
  endtask

  bit [11:0] addrPool [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                               12'hF12, 12'h7C0, 12'h301, 12'hB01};

  initial begin
    reset = 1'b1;
    applyStimulus(12'h300, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    clockStep();
    clockStep();
    reset = 1'b0;

    // Reset values and read-only constants
    applyStimulus(12'h300, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rst.mstatus", bus.csr_rdata, 32'h1800);
    checkOutput("rst.illegal", bus.csr_illegal, 1'b0);
    checkAll("rst");
    clockStep();
    applyStimulus(12'hF11, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rst.mvendorid", bus.csr_rdata, 32'h79737978);
    clockStep();
    applyStimulus(12'hF12, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rst.marchid", bus.csr_rdata, 32'h016FBCBD);
    checkOutput("rst.marchidIll", bus.csr_illegal, 1'b0);
    clockStep();
    applyStimulus(12'h7C0, 2'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("unmapped.illegal", bus.csr_illegal, 1'b1);
    checkOutput("unmapped.rdata", bus.csr_rdata, 32'h0);
    clockStep();

    // mstatus WARL with RW/RC/RS
    applyStimulus(12'h300, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rw.oldValue", bus.csr_rdata, 32'h1800);
    clockStep();
    applyStimulus(12'h300, 2'd3, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rw.mstatus", bus.csr_rdata, 32'h1888);
    clockStep();
    applyStimulus(12'h300, 2'd2, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rc.mstatus", bus.csr_rdata, 32'h1880);
    clockStep();
    applyStimulus(12'hF11, 2'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rs.mstatus", bus.mstatus_out, 32'h1888);
    checkOutput("roWrite.illegal", bus.csr_illegal, 1'b1);
    checkOutput("roWrite.rdata", bus.csr_rdata, 32'h0);
    clockStep();
    applyStimulus(12'hF11, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("roWrite.after", bus.csr_rdata, 32'h79737978);
    checkOutput("roWrite.mstatus", bus.mstatus_out, 32'h1888);
    clockStep();

    // Vectored trap entry and mret
    applyStimulus(12'h305, 2'd1, 32'h8000_0001, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    clockStep();
    applyStimulus(12'h300, 2'd0, 32'h0, 1'b1, 32'h8000_0007, 32'h8000_1236, 1'b0, 2'd0);
    checkOutput("trap.target", bus.trap_target, 32'h8000_001C);
    checkOutput("trap.mtvec", bus.mtvec_out, 32'h8000_0001);
    clockStep();
    applyStimulus(12'h341, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0);
    checkOutput("trap.mepc", bus.csr_rdata, 32'h8000_1234);
    checkOutput("trap.mcause", bus.mcause_out, 32'h8000_0007);
    checkOutput("trap.mie", bus.mie_out, 1'b0);
    checkOutput("trap.mstatus", bus.mstatus_out, 32'h1880);
    checkOutput("mret.target", bus.mret_target, 32'h8000_1234);
    clockStep();
    applyStimulus(12'h300, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("mret.mstatus", bus.csr_rdata, 32'h1888);
    checkOutput("mret.mie", bus.mie_out, 1'b1);
    clockStep();

    // Coinciding trap, mret and CSR write: only the trap lands
    applyStimulus(12'h340, 2'd1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    clockStep();
    applyStimulus(12'h340, 2'd1, 32'hDEAD_BEEF, 1'b1, 32'h2, 32'h100, 1'b1, 2'd0);
    checkOutput("prio.target", bus.trap_target, 32'h8000_0000);
    checkOutput("prio.rdata", bus.csr_rdata, 32'h1234_5678);
    clockStep();
    applyStimulus(12'h340, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("prio.mscratch", bus.csr_rdata, 32'h1234_5678);
    checkOutput("prio.mepc", bus.mepc_out, 32'h100);
    checkOutput("prio.mcause", bus.mcause_out, 32'h2);
    checkOutput("prio.mstatus", bus.mstatus_out, 32'h1880);
    clockStep();

    // mcycle carry across halves and write suppression
    applyStimulus(12'hB00, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    clockStep();
    applyStimulus(12'hB80, 2'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    clockStep();
    applyStimulus(12'hB00, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("mcycle.lowHeld", bus.csr_rdata, 32'hFFFF_FFFF);
    clockStep();
    applyStimulus(12'hB80, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("mcycle.carry", bus.csr_rdata, 32'h1);
    clockStep();
    applyStimulus(12'hB00, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("mcycle.lowWrapped", bus.csr_rdata, 32'h1);
    clockStep();

    // minstret write beats the retire increment, then counts by retire_cnt
    applyStimulus(12'hB02, 2'd1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 2'd3);
    clockStep();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(12'hB02, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd3);
      if (i == 0) checkOutput("minstret.written", bus.csr_rdata, 32'h10);
      clockStep();
    end
    applyStimulus(12'hB02, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("minstret.plus12", bus.csr_rdata, 32'h1C);
    clockStep();
    applyStimulus(12'hB82, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("minstret.high", bus.csr_rdata, 32'h0);
    clockStep();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(addrPool[$urandom_range(0, 13)], 2'($urandom_range(0, 3)),
                    $urandom(), ($urandom_range(0, 7) == 0),
                    {1'($urandom_range(0, 1)), 31'($urandom_range(0, 40))},
                    $urandom(), ($urandom_range(0, 7) == 0),
                    2'($urandom_range(0, 3)));
      checkAll("rand");
      clockStep();
    end

    // Reset mid-stream dominates trap, mret and CSR write
    reset = 1'b1;
    applyStimulus(12'h340, 2'd1, 32'hFFFF, 1'b1, 32'h8000_0003, 32'h444, 1'b1, 2'd3);
    clockStep();
    reset = 1'b0;
    applyStimulus(12'h300, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rst2.mstatus", bus.csr_rdata, 32'h1800);
    checkOutput("rst2.mepc", bus.mepc_out, 32'h0);
    checkOutput("rst2.mcause", bus.mcause_out, 32'h0);
    checkOutput("rst2.mtvec", bus.mtvec_out, 32'h0);
    checkAll("rst2");
    clockStep();
    applyStimulus(12'hB00, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rst2.mcycle", bus.csr_rdata, 32'h1);
    clockStep();
    applyStimulus(12'h340, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    checkOutput("rst2.mscratch", bus.csr_rdata, 32'h0);
    clockStep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
